// File: rtl/ds_sequencer.sv
// ds_sequencer: DS1302 init/poll scheduler driving the one-hot cmd handshake.
// Ports: clk, rst_n, cmd/cmd_done/rd_data, resync_req, hour/minute/second, time_valid/upd, busy, err.
module ds_sequencer #(
  parameter int POLL_CYCLES    = 50_000_000,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] cmd,
  input  logic       cmd_done,
  input  logic [7:0] rd_data,
  input  logic       resync_req,
  output logic [7:0] hour,
  output logic [7:0] minute,
  output logic [7:0] second,
  output logic       time_valid,
  output logic       time_upd,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {
    S_ISSUE,
    S_GAP,
    S_WAIT
  } state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int PW = $clog2(POLL_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] P_LAST = PW'(POLL_CYCLES - 1);

  state_t      state;
  logic [2:0]  step;
  logic [TW-1:0] tcnt;
  logic [PW-1:0] pcnt;
  logic        resync_pend;
  logic        abort;
  logic [7:0]  sh_h;
  logic [7:0]  sh_m;
  logic [6:0]  sh_s;
  logic        is_read;
  logic        resync;

  assign is_read = (step >= 3'd5);
  assign resync  = resync_pend | resync_req;

  function automatic logic [7:0] step_cmd(input logic [2:0] s);
    return 8'h80 >> s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_ISSUE;
      step        <= '0;
      tcnt        <= '0;
      pcnt        <= '0;
      resync_pend <= 1'b0;
      abort       <= 1'b0;
      sh_h        <= '0;
      sh_m        <= '0;
      sh_s        <= '0;
      cmd         <= '0;
      hour        <= '0;
      minute      <= '0;
      second      <= '0;
      time_valid  <= 1'b0;
      time_upd    <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      time_upd <= 1'b0;
      unique case (state)
        S_ISSUE: begin
          // A resync during init is redundant; during reads it defers.
          if (resync_req) resync_pend <= is_read;
          if (cmd == '0) begin
            // First cycle out of reset: present the command.
            cmd  <= step_cmd(step);
            busy <= 1'b1;
            tcnt <= '0;
          end else if (cmd_done) begin
            unique case (1'b1)
              (step == 3'd5): sh_h <= rd_data;
              (step == 3'd6): sh_m <= rd_data;
              (step == 3'd7): sh_s <= rd_data[6:0];
              default: ;
            endcase
            cmd   <= '0;
            state <= S_GAP;
          end else if (tcnt == T_LAST) begin
            cmd        <= '0;
            err        <= 1'b1;
            time_valid <= 1'b0;
            abort      <= 1'b1;
            state      <= S_GAP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_GAP: begin
          if (abort || (is_read && resync)) begin
            if (is_read && resync) begin
              err        <= 1'b0;
              time_valid <= 1'b0;
            end
            abort       <= 1'b0;
            resync_pend <= 1'b0;
            step        <= '0;
            cmd         <= step_cmd(3'd0);
            tcnt        <= '0;
            state       <= S_ISSUE;
          end else if (step == 3'd7) begin
            // Whole triple lands on one edge.
            hour        <= sh_h;
            minute      <= sh_m;
            second      <= {1'b0, sh_s};
            time_valid  <= 1'b1;
            time_upd    <= 1'b1;
            busy        <= 1'b0;
            resync_pend <= 1'b0;
            pcnt        <= P_LAST;
            state       <= S_WAIT;
          end else begin
            if (resync_req) resync_pend <= is_read;
            step  <= step + 3'd1;
            cmd   <= step_cmd(step + 3'd1);
            tcnt  <= '0;
            state <= S_ISSUE;
          end
        end
        S_WAIT: begin
          if (resync) begin
            err         <= 1'b0;
            time_valid  <= 1'b0;
            resync_pend <= 1'b0;
            step        <= '0;
            cmd         <= step_cmd(3'd0);
            busy        <= 1'b1;
            tcnt        <= '0;
            state       <= S_ISSUE;
          end else if (pcnt == '0) begin
            step  <= 3'd5;
            cmd   <= step_cmd(3'd5);
            busy  <= 1'b1;
            tcnt  <= '0;
            state <= S_ISSUE;
          end else begin
            pcnt <= pcnt - 1'b1;
          end
        end
        default: state <= S_ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_ds_sequencer.sv
// tb_ds_sequencer: directed bench for ds_sequencer with a cmd_done responder.
// Ports: none; drives clk/rst_n, responder, resync_req, checks published time.
module tb_ds_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cmd;
  logic       cmd_done;
  logic [7:0] rd_data;
  logic       resync_req;
  logic [7:0] hour;
  logic [7:0] minute;
  logic [7:0] second;
  logic       time_valid;
  logic       time_upd;
  logic       busy;
  logic       err;

  int         n_pass = 0;
  int         n_total = 0;
  int         resp_delay = 5;
  logic [7:0] hold_cmd = 8'h00;
  logic [7:0] rd_h = 8'h08;
  logic [7:0] rd_m = 8'h15;
  logic [7:0] rd_s = 8'hA7;

  always #5 clk = ~clk;

  ds_sequencer #(
    .POLL_CYCLES(16),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd(cmd),
    .cmd_done(cmd_done),
    .rd_data(rd_data),
    .resync_req(resync_req),
    .hour(hour),
    .minute(minute),
    .second(second),
    .time_valid(time_valid),
    .time_upd(time_upd),
    .busy(busy),
    .err(err)
  );

  initial begin : responder
    logic [7:0] last;
    int age;
    cmd_done = 1'b0;
    rd_data  = 8'h00;
    last     = 8'h00;
    age      = 0;
    forever begin
      @(negedge clk);
      cmd_done = 1'b0;
      if (cmd === 8'h00) begin
        last = 8'h00;
        age  = 0;
      end else begin
        if (cmd !== last) begin
          last = cmd;
          age  = 1;
        end else begin
          age++;
        end
        if (age == resp_delay && cmd !== hold_cmd) begin
          cmd_done = 1'b1;
          if (cmd === 8'h04) rd_data = rd_h;
          else if (cmd === 8'h02) rd_data = rd_m;
          else if (cmd === 8'h01) rd_data = rd_s;
          else rd_data = 8'h00;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got hang, want finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cmd(input logic [7:0] v, input int budget,
                          output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (cmd === v) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_upd(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (time_upd === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic hold_len(input logic [7:0] v, output int n);
    n = 0;
    while (cmd === v && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n      = 1'b0;
    resync_req = 1'b0;
    tick(2);
    n_total++;
    if ({cmd, hour, minute, second} !== 32'h0) $display(
      "FAIL reset_data: got %h %h %h %h want 0", cmd, hour, minute, second);
    else n_pass++;
    n_total++;
    if ({time_valid, time_upd, busy, err} !== 4'b0) $display(
      "FAIL reset_flags: got %b want 0000",
      {time_valid, time_upd, busy, err});
    else n_pass++;
    rst_n = 1'b1;
    tick(1);
    n_total++;
    if (cmd !== 8'h80 || busy !== 1'b1) $display(
      "FAIL first_cmd: got cmd=%h busy=%b want 80 1", cmd, busy);
    else n_pass++;
  endtask

  task automatic test_init_and_read;
    logic [7:0] exp [8] = '{8'h80, 8'h40, 8'h20, 8'h10,
                            8'h08, 8'h04, 8'h02, 8'h01};
    bit ok;
    int n;
    for (int i = 0; i < 8; i++) begin
      wait_cmd(exp[i], 20, ok);
      n_total++;
      if (!ok) $display("FAIL cmd_seq[%0d]: got %h want %h", i, cmd, exp[i]);
      else n_pass++;
      hold_len(exp[i], n);
      n_total++;
      if (n != 5) $display("FAIL cmd_hold[%0d]: got %0d want 5", i, n);
      else n_pass++;
      n_total++;
      if (cmd !== 8'h00 || busy !== 1'b1 || time_upd !== 1'b0) $display(
        "FAIL gap[%0d]: got cmd=%h busy=%b upd=%b want 00 1 0",
        i, cmd, busy, time_upd);
      else n_pass++;
      tick(1);
      if (i < 7) begin
        n_total++;
        if (cmd !== exp[i+1]) $display(
          "FAIL gap_len[%0d]: got %h want %h", i, cmd, exp[i+1]);
        else n_pass++;
      end
    end
    n_total++;
    if (time_upd !== 1'b1 || time_valid !== 1'b1 || busy !== 1'b0)
      $display("FAIL publish_flags: got upd=%b valid=%b busy=%b want 1 1 0",
               time_upd, time_valid, busy);
    else n_pass++;
    n_total++;
    if ({hour, minute, second} !== 24'h081527) $display(
      "FAIL publish_time: got %h %h %h want 08 15 27", hour, minute, second);
    else n_pass++;
    tick(1);
    n_total++;
    if (time_upd !== 1'b0) $display("FAIL upd_pulse: got %b want 0", time_upd);
    else n_pass++;
    hold_len(8'h00, n);
    n_total++;
    if (n + 1 != 16 || cmd !== 8'h04) $display(
      "FAIL poll_interval: got %0d cycles cmd=%h want 16 04", n + 1, cmd);
    else n_pass++;
  endtask

  task automatic test_poll;
    bit ok;
    rd_h = 8'h23;
    rd_m = 8'h59;
    rd_s = 8'hD9;
    wait_upd(200, ok);
    n_total++;
    if (!ok) $display("FAIL poll_upd: got no time_upd want pulse");
    else n_pass++;
    n_total++;
    if ({hour, minute, second} !== 24'h235959 || time_valid !== 1'b1)
      $display("FAIL poll_time: got %h %h %h v=%b want 23 59 59 1",
               hour, minute, second, time_valid);
    else n_pass++;
  endtask

  task automatic test_resync_wait;
    bit ok;
    tick(5);
    resync_req = 1'b1;
    tick(1);
    resync_req = 1'b0;
    n_total++;
    if (cmd !== 8'h80 || time_valid !== 1'b0 || busy !== 1'b1) $display(
      "FAIL resync_wait: got cmd=%h valid=%b busy=%b want 80 0 1",
      cmd, time_valid, busy);
    else n_pass++;
    wait_upd(300, ok);
    n_total++;
    if (!ok || time_valid !== 1'b1) $display(
      "FAIL resync_wait_done: got upd=%b valid=%b want 1 1",
      time_upd, time_valid);
    else n_pass++;
  endtask

  task automatic test_timeout;
    bit ok;
    int n;
    hold_cmd   = 8'h20;
    resync_req = 1'b1;
    tick(1);
    resync_req = 1'b0;
    wait_cmd(8'h20, 100, ok);
    n_total++;
    if (!ok) $display("FAIL to_reach: got %h want 20", cmd);
    else n_pass++;
    hold_len(8'h20, n);
    n_total++;
    if (n != 64) $display("FAIL to_len: got %0d want 64", n);
    else n_pass++;
    n_total++;
    if (cmd !== 8'h00 || err !== 1'b1 || time_valid !== 1'b0) $display(
      "FAIL to_abort: got cmd=%h err=%b valid=%b want 00 1 0",
      cmd, err, time_valid);
    else n_pass++;
    tick(1);
    hold_cmd = 8'h00;
    n_total++;
    if (cmd !== 8'h80) $display("FAIL to_restart: got %h want 80", cmd);
    else n_pass++;
    wait_upd(300, ok);
    n_total++;
    if (!ok || err !== 1'b1 || time_valid !== 1'b1) $display(
      "FAIL to_sticky: got upd=%b err=%b valid=%b want 1 1 1",
      time_upd, err, time_valid);
    else n_pass++;
  endtask

  task automatic test_resync_read;
    bit ok;
    int n;
    wait_cmd(8'h02, 100, ok);
    n_total++;
    if (!ok) $display("FAIL rr_reach: got %h want 02", cmd);
    else n_pass++;
    resync_req = 1'b1;
    tick(1);
    resync_req = 1'b0;
    hold_len(8'h02, n);
    n_total++;
    if (n != 4 || cmd !== 8'h00) $display(
      "FAIL rr_complete: got %0d cmd=%h want 4 00", n, cmd);
    else n_pass++;
    tick(1);
    n_total++;
    if (cmd !== 8'h80 || time_upd !== 1'b0 || err !== 1'b0) $display(
      "FAIL rr_reinit: got cmd=%h upd=%b err=%b want 80 0 0",
      cmd, time_upd, err);
    else n_pass++;
    wait_upd(300, ok);
    n_total++;
    if (!ok || err !== 1'b0 || time_valid !== 1'b1) $display(
      "FAIL rr_done: got upd=%b err=%b valid=%b want 1 0 1",
      time_upd, err, time_valid);
    else n_pass++;
  endtask

  task automatic test_simultaneous;
    bit ok;
    int n;
    resp_delay = 64;
    wait_cmd(8'h04, 100, ok);
    hold_len(8'h04, n);
    n_total++;
    if (!ok || n != 64) $display("FAIL sim_len: got %0d want 64", n);
    else n_pass++;
    n_total++;
    if (cmd !== 8'h00 || err !== 1'b0) $display(
      "FAIL sim_err: got cmd=%h err=%b want 00 0", cmd, err);
    else n_pass++;
    tick(1);
    n_total++;
    if (cmd !== 8'h02) $display("FAIL sim_advance: got %h want 02", cmd);
    else n_pass++;
    wait_upd(500, ok);
    resp_delay = 5;
    n_total++;
    if (!ok || err !== 1'b0 || time_valid !== 1'b1) $display(
      "FAIL sim_done: got upd=%b err=%b valid=%b want 1 0 1",
      time_upd, err, time_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    bit ok;
    wait_cmd(8'h04, 100, ok);
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (!ok || {cmd, hour, minute, second, time_valid, time_upd, busy, err}
        !== 36'h0) $display(
      "FAIL rst_async: got cmd=%h h=%h m=%h s=%h flags=%b want all 0",
      cmd, hour, minute, second, {time_valid, time_upd, busy, err});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    n_total++;
    if (cmd !== 8'h80) $display("FAIL rst_restart: got %h want 80", cmd);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_init_and_read();
    test_poll();
    test_resync_wait();
    test_timeout();
    test_resync_read();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
